mem_stage_pipe: RTL

//  Parametrised E->M pipeline register: holds/flushes a valid bit and carries PC/IR/AO/RT.

---
 rtl/mem_stage_pipe.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_pipe.sv
// E->M pipeline register. It classifies load/store addresses when an instruction is
// captured and stalls the stage while a device-window access runs on the req/ack bus.
module mem_stage_pipe #(
  parameter int unsigned   DW        = 32,
  parameter logic [DW-1:0] RAM_TOP   = 'h2FFF,
  parameter logic [DW-1:0] DEV0_BASE = 'h7F00,
  parameter logic [DW-1:0] DEV1_BASE = 'h7F10,
  parameter int unsigned   DEV_RSIZE = 12,
  parameter int unsigned   DEV_WSIZE = 8,
  parameter int unsigned   TIMEOUT   = 15
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          flush,
  input  logic          valid_e,
  input  logic [31:0]   ir_e,
  input  logic [DW-1:0] pc_e,
  input  logic [DW-1:0] ao_e,
  input  logic [DW-1:0] rt_e,
  input  logic [4:0]    excode_e,
  input  logic          dev_ack,
  input  logic [DW-1:0] dev_rdata,
  output logic          valid_m,
  output logic [31:0]   ir_m,
  output logic [DW-1:0] pc_m,
  output logic [DW-1:0] ao_m,
  output logic [DW-1:0] rt_m,
  output logic [4:0]    excode_m,
  output logic          dev_req,
  output logic          dev_we,
  output logic [DW-1:0] dev_addr,
  output logic [DW-1:0] dev_wdata,
  output logic [DW-1:0] dev_rdata_m,
  output logic          busy,
  output logic [1:0]    fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  localparam logic [DW-1:0] DEV0_RLAST = DEV0_BASE + DW'(DEV_RSIZE - 1);
  localparam logic [DW-1:0] DEV1_RLAST = DEV1_BASE + DW'(DEV_RSIZE - 1);
  localparam logic [DW-1:0] DEV0_WLAST = DEV0_BASE + DW'(DEV_WSIZE - 1);
  localparam logic [DW-1:0] DEV1_WLAST = DEV1_BASE + DW'(DEV_WSIZE - 1);
  localparam logic [7:0]    TIMEOUT_C  = 8'(TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cnt_inc;

  logic [5:0] op_e;
  logic       is_lw, is_lh, is_lb, is_sw, is_sh, is_sb;
  logic       is_load, is_store;
  logic       in_ram, in_rwin, in_wwin;
  logic       ld_fault, st_fault;
  logic [4:0] excode_cap;
  logic       dev_start;
  logic       load_edge;
  logic       ack_hit, timeout_hit;

  // Capture-time classification of the E-stage access
  assign op_e     = ir_e[31:26];
  assign is_lw    = (op_e == OP_LW);
  assign is_lh    = (op_e == OP_LH) || (op_e == OP_LHU);
  assign is_lb    = (op_e == OP_LB) || (op_e == OP_LBU);
  assign is_sw    = (op_e == OP_SW);
  assign is_sh    = (op_e == OP_SH);
  assign is_sb    = (op_e == OP_SB);
  assign is_load  = is_lw || is_lh || is_lb;
  assign is_store = is_sw || is_sh || is_sb;

  assign in_ram  = (ao_e <= RAM_TOP);
  assign in_rwin = ((ao_e >= DEV0_BASE) && (ao_e <= DEV0_RLAST)) ||
                   ((ao_e >= DEV1_BASE) && (ao_e <= DEV1_RLAST));
  assign in_wwin = ((ao_e >= DEV0_BASE) && (ao_e <= DEV0_WLAST)) ||
                   ((ao_e >= DEV1_BASE) && (ao_e <= DEV1_WLAST));

  // Devices only accept whole-word accesses, so sub-word ops in a read window fault
  assign ld_fault = (is_lw && (ao_e[1:0] != 2'b00)) || (is_lh && ao_e[0]) ||
                    (!in_ram && !in_rwin) || ((is_lh || is_lb) && in_rwin);
  assign st_fault = (is_sw && (ao_e[1:0] != 2'b00)) || (is_sh && ao_e[0]) ||
                    (!in_ram && !in_wwin) || ((is_sh || is_sb) && in_rwin);

  always_comb begin
    excode_cap = 5'd0;
    if (excode_e != 5'd0) begin
      excode_cap = excode_e;
    end else if (valid_e) begin
      if (is_load && ld_fault) begin
        excode_cap = EXC_ADEL;
      end else if (is_store && st_fault) begin
        excode_cap = EXC_ADES;
      end
    end
  end

  assign dev_start = valid_e && (excode_cap == 5'd0) && !in_ram &&
                     ((is_load && in_rwin) || (is_store && in_wwin));

  assign busy      = (state_q == S_WAIT);
  assign load_edge = !flush && !busy && en;
  assign cnt_inc   = cnt_q + 8'd1;
  assign ack_hit     = (state_q == S_WAIT) && dev_ack;
  assign timeout_hit = (state_q == S_WAIT) && !dev_ack && (cnt_inc == TIMEOUT_C);

  // Bus handshake: dev_req stays high for every WAIT cycle; a transfer completes on the
  // first rising edge that samples dev_ack high while dev_req is high. dev_rdata is valid
  // alongside dev_ack; dev_ack seen while dev_req is low has no effect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else if (dev_ack || timeout_hit) begin
          state_d = S_DONE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d = 8'd0;
        if (load_edge && dev_start) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_m     <= 1'b0;
      ir_m        <= '0;
      pc_m        <= '0;
      ao_m        <= '0;
      rt_m        <= '0;
      excode_m    <= '0;
      dev_rdata_m <= '0;
    end else if (flush) begin
      valid_m  <= 1'b0;
      ir_m     <= '0;
      excode_m <= '0;
    end else if (busy) begin
      if (ack_hit) begin
        dev_rdata_m <= dev_rdata;
      end else if (timeout_hit) begin
        excode_m <= EXC_DBE;
      end
    end else if (en) begin
      valid_m  <= valid_e;
      ir_m     <= ir_e;
      pc_m     <= pc_e;
      ao_m     <= ao_e;
      rt_m     <= rt_e;
      excode_m <= excode_cap;
    end
  end

  assign dev_req   = busy;
  assign dev_we    = busy && ((ir_m[31:26] == OP_SW) || (ir_m[31:26] == OP_SH) ||
                              (ir_m[31:26] == OP_SB));
  assign dev_addr  = ao_m;
  assign dev_wdata = rt_m;
  assign fsm_state = state_q;

endmodule
